// File: rtl/uart_rx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_if : serial pin, frame configuration and byte/status outputs. Rev 1.0
// ---------------------------------------------------------------------------
interface uart_rx_if;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Par_Err;
   logic       Stp_Err;
   logic       busy;

   modport master (
      output RX_IN,
      output PAR_EN,
      output PAR_TYP,
      input  P_DATA,
      input  Data_Valid,
      input  Par_Err,
      input  Stp_Err,
      input  busy
   );

   modport slave (
      input  RX_IN,
      input  PAR_EN,
      input  PAR_TYP,
      output P_DATA,
      output Data_Valid,
      output Par_Err,
      output Stp_Err,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver, 8 data bits, optional parity.  Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int PRESCALE = 8
) (
   input  logic      CLK,
   input  logic      RST,
   uart_rx_if.slave  bus
);

   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] C_SMP_A = CW'(PRESCALE/2 - 1);
   localparam logic [CW-1:0] C_SMP_B = CW'(PRESCALE/2);
   localparam logic [CW-1:0] C_DEC   = CW'(PRESCALE/2 + 1);
   localparam logic [CW-1:0] C_LAST  = CW'(PRESCALE - 1);

   if ((PRESCALE < 4) || (PRESCALE > 32) || (PRESCALE % 2 != 0)) begin : g_bad_prescale
      $error("uart_rx: PRESCALE must be even and within 4..32");
   end

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t        state_q;
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    bit_cnt_q;
   logic [1:0]    smp_q;
   logic [7:0]    shift_q;
   logic          par_en_q;
   logic          par_typ_q;
   logic          par_err_q;
   logic [7:0]    p_data_q;
   logic          valid_q;
   logic          par_pulse_q;
   logic          stp_pulse_q;
   logic          busy_q;

   logic          rx_s;
   logic          maj;
   logic          dec_edge;
   logic          last_edge;
   logic [CW-1:0] cnt_d;
   logic [3:0]    bit_cnt_d;
   logic [7:0]    shift_d;
   logic          par_exp;
   logic          data_done;

   assign rx_s      = sync_q[1];
   assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
   assign dec_edge  = (cnt_q == C_DEC);
   assign last_edge = (cnt_q == C_LAST);
   assign cnt_d     = last_edge ? '0 : cnt_q + 1'b1;
   assign bit_cnt_d = bit_cnt_q + 4'd1;
   assign shift_d   = {maj, shift_q[7:1]};
   assign par_exp   = (^shift_q) ^ par_typ_q;
   // With PRESCALE=4 the decision and the cell's last edge coincide.
   assign data_done = ((dec_edge ? bit_cnt_d : bit_cnt_q) == 4'd8);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         bit_cnt_q   <= 4'd0;
         smp_q       <= 2'b00;
         shift_q     <= 8'h00;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
         par_err_q   <= 1'b0;
         p_data_q    <= 8'h00;
         valid_q     <= 1'b0;
         par_pulse_q <= 1'b0;
         stp_pulse_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], bus.RX_IN};
         valid_q     <= 1'b0;
         par_pulse_q <= 1'b0;
         stp_pulse_q <= 1'b0;

         if (state_q != S_IDLE) begin
            cnt_q <= cnt_d;
         end
         if (cnt_q == C_SMP_A) begin
            smp_q[0] <= rx_s;
         end
         if (cnt_q == C_SMP_B) begin
            smp_q[1] <= rx_s;
         end

         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_q   <= S_START;
                  cnt_q     <= CW'(1);
                  bit_cnt_q <= 4'd0;
                  par_en_q  <= bus.PAR_EN;
                  par_typ_q <= bus.PAR_TYP;
                  par_err_q <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end

            S_START: begin
               if (dec_edge && maj) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (last_edge) begin
                  state_q <= S_DATA;
               end
            end

            S_DATA: begin
               if (dec_edge) begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_d;
               end
               if (last_edge && data_done) begin
                  bit_cnt_q <= 4'd0;
                  state_q   <= par_en_q ? S_PARITY : S_STOP;
               end
            end

            S_PARITY: begin
               if (dec_edge) begin
                  par_err_q <= (maj != par_exp);
               end
               if (last_edge) begin
                  state_q <= S_STOP;
               end
            end

            S_STOP: begin
               if (dec_edge) begin
                  cnt_q       <= '0;
                  valid_q     <= maj & ~par_err_q;
                  par_pulse_q <= par_err_q;
                  stp_pulse_q <= ~maj;
                  if (maj && !par_err_q) begin
                     p_data_q <= shift_q;
                  end
                  // A low stop bit may be a break; hold off start detection until the line recovers.
                  state_q <= maj ? S_IDLE : S_WAIT_IDLE;
                  busy_q  <= ~maj;
               end
            end

            S_WAIT_IDLE: begin
               if (rx_s) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.P_DATA     = p_data_q;
   assign bus.Data_Valid = valid_q;
   assign bus.Par_Err    = par_pulse_q;
   assign bus.Stp_Err    = stp_pulse_q;
   assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx : randomized frames against a frame-level timing/outcome model.
// ---------------------------------------------------------------------------
module tb_uart_rx;
   localparam int P     = 8;
   localparam int NEVER = 32'h7fff_ffff;

   logic CLK = 1'b0;
   logic RST;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Expected behaviour of the frame in flight: busy window, pulse edge, outcome.
   int         bs = 0;
   int         be = 0;
   int         exp_cyc = -1;
   bit         exp_dv, exp_pe, exp_se;
   logic [7:0] exp_data;
   logic [7:0] pdata_m = 8'h00;

   uart_rx_if bus ();

   uart_rx #(.PRESCALE(P)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   always @(posedge CLK) begin
      #1;
      if (cyc == exp_cyc) begin
         if (exp_dv) pdata_m = exp_data;
         check_eq("pulses", {bus.Data_Valid, bus.Par_Err, bus.Stp_Err}, {exp_dv, exp_pe, exp_se});
      end else begin
         check_eq("pulses", {bus.Data_Valid, bus.Par_Err, bus.Stp_Err}, 3'b000);
      end
      check_eq("p_data", bus.P_DATA, pdata_m);
      check_eq("busy", bus.busy, (cyc >= bs && cyc < be));
   end

   task automatic model_reset();
      bs      = 0;
      be      = 0;
      exp_cyc = -1;
      pdata_m = 8'h00;
   endtask

   // Called at a falling edge; drives one whole frame, MSB of timing derived from E0.
   task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                             input bit pflip, input bit stop, input int hold);
      logic bits[$];
      int   e0, f, dec;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back((^d) ^ ptyp ^ pflip);
      bits.push_back(stop);
      f   = pen ? 11 : 10;
      e0  = cyc + 1;
      dec = e0 + 2 + (f - 1) * P + P / 2 + 1;
      bs       = e0 + 2;
      be       = stop ? dec : NEVER;
      exp_cyc  = dec;
      exp_pe   = pen && pflip;
      exp_se   = !stop;
      exp_dv   = !exp_pe && stop;
      exp_data = d;
      bus.PAR_EN  = pen;
      bus.PAR_TYP = ptyp;
      foreach (bits[i]) begin
         bus.RX_IN = bits[i];
         for (int k = 0; k < P; k++) begin
            @(negedge CLK);
            if (i == 0 && k == 2) begin
               bus.PAR_EN  = 1'($urandom);
               bus.PAR_TYP = 1'($urandom);
            end
         end
      end
      if (!stop) begin
         bus.RX_IN = 1'b0;
         repeat (hold) @(negedge CLK);
         bus.RX_IN = 1'b1;
         be = cyc + 1 + 2;
         @(negedge CLK);
      end
      bus.RX_IN = 1'b1;
   endtask

   initial begin
      int         e0;
      logic [7:0] d;
      bit         pen, ptyp, pflip, stop;
      int         hold, gap;

      RST         = 1'b1;
      bus.RX_IN   = 1'b1;
      bus.PAR_EN  = 1'b0;
      bus.PAR_TYP = 1'b0;
      repeat (5) @(negedge CLK);
      RST = 1'b0;
      repeat (200) @(negedge CLK);

      // Plain 8N1, then a back-to-back frame with an exact one-cell stop bit.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      repeat (10) @(negedge CLK);

      // Even parity: good, then corrupted.
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      repeat (5) @(negedge CLK);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0);
      repeat (5) @(negedge CLK);

      // Odd parity: good, then corrupted.
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 0);
      repeat (5) @(negedge CLK);
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      repeat (5) @(negedge CLK);

      // Three-cycle glitch is rejected at the start-cell decision.
      bus.RX_IN = 1'b0;
      e0 = cyc + 1;
      bs = e0 + 2;
      be = e0 + 2 + P / 2 + 1;
      exp_cyc = -1;
      repeat (3) @(negedge CLK);
      bus.RX_IN = 1'b1;
      repeat (20) @(negedge CLK);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      repeat (5) @(negedge CLK);

      // Framing error followed by a break, then recovery.
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 40);
      repeat (5) @(negedge CLK);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      repeat (5) @(negedge CLK);

      // Reset in the middle of a frame clears outputs immediately.
      bus.RX_IN = 1'b0;
      e0 = cyc + 1;
      bs = e0 + 2;
      be = NEVER;
      exp_cyc = -1;
      repeat (30) @(negedge CLK);
      RST = 1'b1;
      bus.RX_IN = 1'b1;
      model_reset();
      #1;
      check_eq("rst_async_pdata", bus.P_DATA, 8'h00);
      check_eq("rst_async_busy", bus.busy, 1'b0);
      check_eq("rst_async_pulses", {bus.Data_Valid, bus.Par_Err, bus.Stp_Err}, 3'b000);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      repeat (5) @(negedge CLK);

      for (int n = 0; n < 40; n++) begin
         d     = 8'($urandom);
         pen   = 1'($urandom);
         ptyp  = 1'($urandom);
         pflip = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 5) != 0);
         hold  = int'($urandom_range(0, 40));
         gap   = int'($urandom_range(0, 12));
         send_frame(d, pen, ptyp, pflip, stop, hold);
         repeat (gap) @(negedge CLK);
      end

      repeat (20) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of `UART_TX` on the same link. It decodes frames of 1 start bit, 8 data bits (LSB first), an optional parity bit and 1 stop bit, oversampled `PRESCALE` times per bit. It delivers each good byte with a one-cycle `Data_Valid` pulse and flags parity and stop (framing) errors. It sits between the `RX_IN` pin and the byte-consuming logic and uses the same `PAR_EN`/`PAR_TYP` configuration as the transmitter.

## Interface
Parameters:
- `PRESCALE`, 8: clock cycles per bit. Must be even, 4..32.

Ports:
- `CLK`  in  1  single clock; all logic on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `RX_IN`  in  1  serial line; idles high; asynchronous to `CLK`.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  1  0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data).
- `P_DATA`  out  8  last good byte; holds until the next good frame.
- `Data_Valid`  out  1  one-cycle pulse when `P_DATA` is updated.
- `Par_Err`  out  1  one-cycle pulse: parity mismatch.
- `Stp_Err`  out  1  one-cycle pulse: stop bit sampled 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input path: `RX_IN` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- Cell timing: every bit cell spans `PRESCALE` edges, indexed 0..P-1. Sample edge 0 of the start cell is the first edge at which the FSM sees `rx_s`=0 while in IDLE.
- Bit value: majority of `rx_s` at edges P/2-1, P/2 and P/2+1. It is evaluated at edge P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on `rx_s`=0, capture `PAR_EN`/`PAR_TYP` into frame registers and go to START. Later changes to these inputs do not affect the frame in progress.
  - START: if the majority is 1 (glitch), return to IDLE at the decision edge with no outputs. Otherwise continue to DATA at the end of the cell.
  - DATA: 8 cells. Each decision shifts the bit in LSB first. After cell 8, go to PARITY if enabled, else STOP.
  - PARITY: compare the sampled bit with the expected parity of the shifted byte. Latch the mismatch.
  - STOP: at the decision edge, register outputs, then:
    - stop=1: go to IDLE (the remaining half stop bit is not waited out, so back-to-back frames are supported).
    - stop=0: go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. No start detection happens while the line is held low (break).
- Output rules at the stop decision edge:
  - No error: `P_DATA` <= byte, `Data_Valid`=1.
  - Any error: `Data_Valid`=0 and `P_DATA` is unchanged. `Par_Err` and `Stp_Err` are each pulsed independently; both may pulse together.
- Reset (including mid-frame): state IDLE, counters 0, `P_DATA`=0x00, `Data_Valid`/`Par_Err`/`Stp_Err`/`busy`=0, synchronizer=1.

## Timing
- Let E0 be the first rising edge at which `RX_IN` is sampled low. Start-cell sample 0 is edge E0+2.
- Let F = 10 without parity, 11 with parity. Pulses assert from edge E0+2+(F-1)·P+P/2+1 for exactly one cycle.
  - P=8, no parity: E0+79.
  - P=8, parity: E0+87.
- `busy` rises at E0+2 and falls at the stop decision edge (or at the glitch decision edge, or on leaving WAIT_IDLE).
- Counters: edge counter is clog2(P) bits and wraps at P-1. Bit counter is 4 bits and clears at frame end.
- Back-to-back frames: a start bit whose falling edge arrives at any point after the previous stop decision is detected.

## Test plan
- Reset, `RX_IN`=1 for 200 cycles: all outputs 0, `P_DATA`=0x00, no pulses. Assert `RST` mid-frame: outputs clear immediately, and the next frame is received correctly.
- P=8, `PAR_EN`=0, send 0xA5 (serial 0,1,0,1,0,0,1,0,1,1): `Data_Valid` is a single pulse at E0+79, `P_DATA`=0xA5, no errors. Repeat back-to-back with 0x3C (stop bit exactly 8 cycles): both bytes received.
- `PAR_EN`=1, `PAR_TYP`=0, send 0x3C with parity 0: valid pulse at E0+87. Resend with parity 1: `Par_Err` pulses, `Data_Valid`=0, `P_DATA` stays 0x3C.
- `PAR_TYP`=1, send 0x01 with parity 0: valid, `P_DATA`=0x01. Send 0x01 with parity 1: `Par_Err` pulses.
- `RX_IN` low for 3 cycles then high: `busy` pulses, no output pulses. A following frame 0x5A is received normally.
- Send 0xFF with stop bit 0, then hold the line low for 40 cycles, then high: `Stp_Err` pulses once with no further frames during the low period. A following frame 0x81 is received.
